// File: rtl/mdu_stage_if.sv
// mdu_stage_if: issue/result handshake between decode, the RV32M unit and MEM/WB.
// master = issuing side, slave = mdu_stage.
interface mdu_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5
);
    logic                      valid_i;
    logic [2:0]                funct3_i;
    logic [DATA_WIDTH-1:0]     data_a_i;
    logic [DATA_WIDTH-1:0]     data_b_i;
    logic [REGISTER_WIDTH-1:0] rd_i;
    logic                      stall_i;
    logic                      ready_o;
    logic                      busy_o;
    logic                      valid_o;
    logic [DATA_WIDTH-1:0]     result_o;
    logic [REGISTER_WIDTH-1:0] rd_o;
    logic                      illegal_o;

    modport master (
        output valid_i, funct3_i, data_a_i, data_b_i, rd_i, stall_i,
        input  ready_o, busy_o, valid_o, result_o, rd_o, illegal_o
    );

    modport slave (
        input  valid_i, funct3_i, data_a_i, data_b_i, rd_i, stall_i,
        output ready_o, busy_o, valid_o, result_o, rd_o, illegal_o
    );
endinterface

// File: rtl/mdu_stage.sv
// mdu_stage: RV32M execute unit, pipelined multiply and iterative restoring divide.
// Define MDU_DIV_EN to build the divider; without it divides return illegal_o.
module mdu_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5,
    parameter int MUL_STAGES     = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    mdu_stage_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DONE = 3'd4;
`ifdef MDU_DIV_EN
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
`endif

    logic [2:0]                r_state;
    logic [CW-1:0]             r_cnt;
    logic [1:0]                r_f3;
    logic [W-1:0]              r_result;
    logic [REGISTER_WIDTH-1:0] r_rd;
    logic                      r_illegal;
    logic [2*W-1:0]            r_ma;
    logic [2*W-1:0]            r_mb;

    logic           w_ready;
    logic           w_accept;
    logic           w_sa;
    logic           w_sb;
    logic [1:0]     w_f3m;
    logic [2*W-1:0] w_ea;
    logic [2*W-1:0] w_eb;
    logic [2*W-1:0] w_mul_fin;
    logic [W-1:0]   w_mul_res;

    assign w_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && !bus.stall_i);
    assign w_accept = bus.valid_i && w_ready;

    assign w_sa = (bus.funct3_i[1:0] != 2'b11);
    assign w_sb = !bus.funct3_i[1];
    assign w_ea = {{W{w_sa & bus.data_a_i[W-1]}}, bus.data_a_i};
    assign w_eb = {{W{w_sb & bus.data_b_i[W-1]}}, bus.data_b_i};

    // MUL_STAGES counts every register from the operands up to result_o
    generate
        if (MUL_STAGES == 1) begin : g_m1
            assign w_mul_fin = w_ea * w_eb;
        end else if (MUL_STAGES == 2) begin : g_m2
            assign w_mul_fin = r_ma * r_mb;
        end else begin : g_mp
            logic [2*W-1:0] r_pipe [MUL_STAGES-2];
            always_ff @(posedge clk_i) begin
                r_pipe[0] <= r_ma * r_mb;
                for (int i = 1; i < MUL_STAGES - 2; i++)
                    r_pipe[i] <= r_pipe[i-1];
            end
            assign w_mul_fin = r_pipe[MUL_STAGES-3];
        end
    endgenerate

    assign w_f3m     = (MUL_STAGES == 1) ? bus.funct3_i[1:0] : r_f3;
    assign w_mul_res = (w_f3m == 2'b00) ? w_mul_fin[W-1:0] : w_mul_fin[2*W-1:W];

`ifdef MDU_DIV_EN
    logic [W-1:0] r_quo;
    logic [W-1:0] r_rem;
    logic [W-1:0] r_dvs;
    logic         r_neg_q;
    logic         r_neg_r;

    logic         w_sgn;
    logic         w_na;
    logic         w_nb;
    logic         w_zero;
    logic         w_ovf;
    logic         w_in_div;
    logic         w_ge;
    logic [W-1:0] w_abs_a;
    logic [W-1:0] w_abs_b;
    logic [W-1:0] w_min;
    logic [W-1:0] w_spec;
    logic [W-1:0] w_qin;
    logic [W-1:0] w_rin;
    logic [W-1:0] w_dvs;
    logic [W-1:0] w_q_nxt;
    logic [W-1:0] w_r_nxt;
    logic [W-1:0] w_fix;
    logic [W:0]   w_rsh;
    logic [W:0]   w_diff;

    assign w_sgn   = !bus.funct3_i[0];
    assign w_na    = w_sgn & bus.data_a_i[W-1];
    assign w_nb    = w_sgn & bus.data_b_i[W-1];
    assign w_abs_a = w_na ? -bus.data_a_i : bus.data_a_i;
    assign w_abs_b = w_nb ? -bus.data_b_i : bus.data_b_i;
    assign w_min   = {1'b1, {(W-1){1'b0}}};
    assign w_zero  = (bus.data_b_i == '0);
    assign w_ovf   = w_sgn && (bus.data_a_i == w_min) && (bus.data_b_i == '1);
    assign w_spec  = bus.funct3_i[1] ? (w_zero ? bus.data_a_i : '0)
                                     : (w_zero ? '1 : w_min);

    // first quotient bit is resolved at acceptance, the rest in DIV
    assign w_in_div = (r_state == S_DIV);
    assign w_qin    = w_in_div ? r_quo : w_abs_a;
    assign w_rin    = w_in_div ? r_rem : '0;
    assign w_dvs    = w_in_div ? r_dvs : w_abs_b;
    assign w_rsh    = {w_rin, w_qin[W-1]};
    assign w_diff   = w_rsh - {1'b0, w_dvs};
    assign w_ge     = !w_diff[W];
    assign w_r_nxt  = w_ge ? w_diff[W-1:0] : w_rsh[W-1:0];
    assign w_q_nxt  = {w_qin[W-2:0], w_ge};
    assign w_fix    = r_f3[1] ? (r_neg_r ? -r_rem : r_rem)
                              : (r_neg_q ? -r_quo : r_quo);
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_f3      <= '0;
            r_result  <= '0;
            r_rd      <= '0;
            r_illegal <= 1'b0;
            r_ma      <= '0;
            r_mb      <= '0;
`ifdef MDU_DIV_EN
            r_quo     <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_MUL: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state  <= S_DONE;
                        r_result <= w_mul_res;
                    end
                end
`ifdef MDU_DIV_EN
                S_DIV: begin
                    r_cnt <= r_cnt - 1'b1;
                    r_quo <= w_q_nxt;
                    r_rem <= w_r_nxt;
                    if (r_cnt == CW'(1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_state  <= S_DONE;
                    r_result <= w_fix;
                end
`endif
                S_DONE: begin
                    if (!bus.stall_i)
                        r_state <= S_IDLE;
                end
                default: ;
            endcase

            if (w_accept) begin
                r_rd      <= bus.rd_i;
                r_f3      <= bus.funct3_i[1:0];
                r_illegal <= 1'b0;
                if (!bus.funct3_i[2]) begin
                    r_ma <= w_ea;
                    r_mb <= w_eb;
                    if (MUL_STAGES == 1) begin
                        r_state  <= S_DONE;
                        r_result <= w_mul_res;
                    end else begin
                        r_state <= S_MUL;
                        r_cnt   <= CW'(MUL_STAGES - 1);
                    end
                end else begin
`ifdef MDU_DIV_EN
                    if (w_zero || w_ovf) begin
                        r_state  <= S_DONE;
                        r_result <= w_spec;
                    end else begin
                        r_state <= S_DIV;
                        r_cnt   <= CW'(W - 1);
                        r_quo   <= w_q_nxt;
                        r_rem   <= w_r_nxt;
                        r_dvs   <= w_abs_b;
                        r_neg_q <= w_na ^ w_nb;
                        r_neg_r <= w_na;
                    end
`else
                    r_state   <= S_DONE;
                    r_result  <= '0;
                    r_illegal <= 1'b1;
`endif
                end
            end
        end
    end

    assign bus.ready_o   = w_ready;
    assign bus.busy_o    = (r_state != S_IDLE);
    assign bus.valid_o   = (r_state == S_DONE);
    assign bus.result_o  = r_result;
    assign bus.rd_o      = r_rd;
    assign bus.illegal_o = r_illegal;
endmodule
